// File: rtl/gat_pkg.sv
// Shared GAT types and width/depth helpers for the input loader and memory controller.
package gat_pkg;

    // Loader sequencing: H sparse data, then node info, then weights.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_H  = 3'd1,
        LOAD_NI = 3'd2,
        LOAD_W  = 3'd3,
        DONE    = 3'd4
    } loader_state_e;

    // Ceil-log2 that never returns less than 1 bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 32'd2) ? 32'd1 : 32'($clog2(v));
    endfunction

    // Bits needed to index an input feature column.
    function automatic int unsigned col_idx_width(input int unsigned num_feature_in);
        return clog2_min1(num_feature_in);
    endfunction

    // Bits needed to hold a row length in 0..NUM_FEATURE_IN.
    function automatic int unsigned row_len_width(input int unsigned num_feature_in);
        return clog2_min1(num_feature_in + 32'd1);
    endfunction

    // Bits needed to hold a subgraph node count.
    function automatic int unsigned num_node_width(input int unsigned max_nodes);
        return clog2_min1(max_nodes);
    endfunction

    // H sparse entry: feature value plus its column index.
    function automatic int unsigned h_data_width(input int unsigned data_width,
                                                 input int unsigned num_feature_in);
        return data_width + col_idx_width(num_feature_in);
    endfunction

    // Node info entry: row length, node id within subgraph, and a flag bit.
    function automatic int unsigned node_info_width(input int unsigned num_feature_in,
                                                    input int unsigned max_nodes);
        return row_len_width(num_feature_in) + num_node_width(max_nodes) + 32'd1;
    endfunction

    // Weight matrix plus two attention vectors.
    function automatic int unsigned weight_depth(input int unsigned num_feature_out,
                                                 input int unsigned num_feature_in);
        return num_feature_out * num_feature_in + 32'd2 * num_feature_out;
    endfunction

    // Address width for a BRAM of the given depth.
    function automatic int unsigned addr_width(input int unsigned depth);
        return clog2_min1(depth);
    endfunction

endpackage

// File: rtl/gat_input_loader_seg_counter.sv
// Segment word counter with clear, increment and a registered last-word flag.
module loader_seg_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [WIDTH-1:0] len_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             last_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             last_q;
    logic             last_d;

    // Next count; len_i is the length of the segment that applies after this edge.
    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        if (clr_i) begin
            cnt_d  = '0;
            last_d = (len_i == WIDTH'(1));
        end else if (inc_i) begin
            cnt_d  = cnt_q + WIDTH'(1);
            last_d = (cnt_d == (len_i - WIDTH'(1)));
        end
    end

    // Count and last-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = last_q;

endmodule

// File: rtl/gat_input_loader.sv
// PS-to-PL input loader: streams H data, node info and weights into their BRAMs.
// Optional build macro LOADER_CHECKSUM_EN adds a running 32-bit checksum output.
module gat_input_loader
    import gat_pkg::*;
#(
    parameter int unsigned IN_W              = 32,
    parameter int unsigned DATA_WIDTH        = 8,
    parameter int unsigned H_NUM_SPARSE_DATA = 242101,
    parameter int unsigned TOTAL_NODES       = 13264,
    parameter int unsigned NUM_FEATURE_IN    = 1433,
    parameter int unsigned NUM_FEATURE_OUT   = 16,
    parameter int unsigned MAX_NODES         = 168,
    localparam int unsigned H_DATA_WIDTH     = h_data_width(DATA_WIDTH, NUM_FEATURE_IN),
    localparam int unsigned NODE_INFO_WIDTH  = node_info_width(NUM_FEATURE_IN, MAX_NODES),
    localparam int unsigned WEIGHT_DEPTH     = weight_depth(NUM_FEATURE_OUT, NUM_FEATURE_IN),
    localparam int unsigned H_DATA_ADDR_W    = addr_width(H_NUM_SPARSE_DATA),
    localparam int unsigned NODE_INFO_ADDR_W = addr_width(TOTAL_NODES),
    localparam int unsigned WEIGHT_ADDR_W    = addr_width(WEIGHT_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [IN_W-1:0]             s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [H_DATA_WIDTH-1:0]     h_data_bram_din,
    output logic                        h_data_bram_ena,
    output logic                        h_data_bram_wea,
    output logic [H_DATA_ADDR_W-1:0]    h_data_bram_addra,
    output logic                        h_data_bram_load_done,
    output logic [NODE_INFO_WIDTH-1:0]  h_node_info_bram_din,
    output logic                        h_node_info_bram_ena,
    output logic                        h_node_info_bram_wea,
    output logic [NODE_INFO_ADDR_W-1:0] h_node_info_bram_addra,
    output logic                        h_node_info_bram_load_done,
    output logic [DATA_WIDTH-1:0]       wgt_bram_din,
    output logic                        wgt_bram_ena,
    output logic                        wgt_bram_wea,
    output logic [WEIGHT_ADDR_W-1:0]    wgt_bram_addra,
    output logic                        wgt_bram_load_done,
    output logic                        load_done
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [31:0]                 checksum
`endif
);

    localparam int unsigned MAX_AW_HN = (H_DATA_ADDR_W > NODE_INFO_ADDR_W) ? H_DATA_ADDR_W
                                                                          : NODE_INFO_ADDR_W;
    localparam int unsigned MAX_AW    = (MAX_AW_HN > WEIGHT_ADDR_W) ? MAX_AW_HN : WEIGHT_ADDR_W;
    // One spare bit so a segment length itself is representable.
    localparam int unsigned CNT_W     = MAX_AW + 1;

    localparam logic [CNT_W-1:0] H_LEN  = CNT_W'(H_NUM_SPARSE_DATA);
    localparam logic [CNT_W-1:0] NI_LEN = CNT_W'(TOTAL_NODES);
    localparam logic [CNT_W-1:0] W_LEN  = CNT_W'(WEIGHT_DEPTH);

    loader_state_e    state_q;
    logic [CNT_W-1:0] seg_cnt;
    logic             seg_last;
    logic             h_wr_last_q;
    logic             ni_wr_last_q;
    logic             w_wr_last_q;

    logic             start_acc_c;
    logic             hs_c;
    logic             seg_end_c;
    logic [CNT_W-1:0] cur_len_c;
    logic [CNT_W-1:0] next_len_c;
    logic             unused_c;

    // Handshake, start acceptance and the segment length that applies after this edge.
    always_comb begin
        start_acc_c = start && ((state_q == IDLE) || (state_q == DONE));
        hs_c        = s_valid && s_ready;
        seg_end_c   = hs_c && seg_last;
        cur_len_c   = W_LEN;
        case (state_q)
            LOAD_H:  cur_len_c = H_LEN;
            LOAD_NI: cur_len_c = NI_LEN;
            default: cur_len_c = W_LEN;
        endcase
        next_len_c = cur_len_c;
        if (start_acc_c) begin
            next_len_c = H_LEN;
        end else if (seg_end_c) begin
            if (state_q == LOAD_H) begin
                next_len_c = NI_LEN;
            end else if (state_q == LOAD_NI) begin
                next_len_c = W_LEN;
            end
        end
    end

    // Upper stream bits and the spare counter bit carry no payload.
    assign unused_c = ^{s_data, seg_cnt};

    loader_seg_counter #(
        .WIDTH (CNT_W)
    ) u_seg_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (start_acc_c || seg_end_c),
        .inc_i  (hs_c),
        .len_i  (next_len_c),
        .cnt_o  (seg_cnt),
        .last_o (seg_last)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] csum_add_c;

    // Payload as it lands in the selected BRAM, zero-extended.
    always_comb begin
        csum_add_c = '0;
        case (state_q)
            LOAD_H:  csum_add_c = 32'(s_data[H_DATA_WIDTH-1:0]);
            LOAD_NI: csum_add_c = 32'(s_data[NODE_INFO_WIDTH-1:0]);
            LOAD_W:  csum_add_c = 32'(s_data[DATA_WIDTH-1:0]);
            default: csum_add_c = '0;
        endcase
    end

    // Running modular sum of accepted words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (start_acc_c) begin
            checksum <= '0;
        end else if (hs_c) begin
            checksum <= checksum + csum_add_c;
        end
    end
`endif

    // Loader FSM with registered BRAM write ports and completion flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q                    <= IDLE;
            s_ready                    <= 1'b0;
            h_data_bram_din            <= '0;
            h_data_bram_ena            <= 1'b0;
            h_data_bram_wea            <= 1'b0;
            h_data_bram_addra          <= '0;
            h_data_bram_load_done      <= 1'b0;
            h_node_info_bram_din       <= '0;
            h_node_info_bram_ena       <= 1'b0;
            h_node_info_bram_wea       <= 1'b0;
            h_node_info_bram_addra     <= '0;
            h_node_info_bram_load_done <= 1'b0;
            wgt_bram_din               <= '0;
            wgt_bram_ena               <= 1'b0;
            wgt_bram_wea               <= 1'b0;
            wgt_bram_addra             <= '0;
            wgt_bram_load_done         <= 1'b0;
            load_done                  <= 1'b0;
            h_wr_last_q                <= 1'b0;
            ni_wr_last_q               <= 1'b0;
            w_wr_last_q                <= 1'b0;
        end else begin
            h_data_bram_ena      <= 1'b0;
            h_data_bram_wea      <= 1'b0;
            h_node_info_bram_ena <= 1'b0;
            h_node_info_bram_wea <= 1'b0;
            wgt_bram_ena         <= 1'b0;
            wgt_bram_wea         <= 1'b0;
            h_wr_last_q          <= 1'b0;
            ni_wr_last_q         <= 1'b0;
            w_wr_last_q          <= 1'b0;

            // Flags follow the final write of their segment by one cycle.
            if (h_wr_last_q) begin
                h_data_bram_load_done <= 1'b1;
            end
            if (ni_wr_last_q) begin
                h_node_info_bram_load_done <= 1'b1;
            end
            if (w_wr_last_q) begin
                wgt_bram_load_done <= 1'b1;
                load_done          <= 1'b1;
            end

            if (start_acc_c) begin
                state_q                    <= LOAD_H;
                s_ready                    <= 1'b1;
                h_data_bram_load_done      <= 1'b0;
                h_node_info_bram_load_done <= 1'b0;
                wgt_bram_load_done         <= 1'b0;
                load_done                  <= 1'b0;
            end else if (hs_c) begin
                case (state_q)
                    LOAD_H: begin
                        h_data_bram_din   <= s_data[H_DATA_WIDTH-1:0];
                        h_data_bram_ena   <= 1'b1;
                        h_data_bram_wea   <= 1'b1;
                        h_data_bram_addra <= seg_cnt[H_DATA_ADDR_W-1:0];
                        if (seg_last) begin
                            state_q     <= LOAD_NI;
                            h_wr_last_q <= 1'b1;
                        end
                    end
                    LOAD_NI: begin
                        h_node_info_bram_din   <= s_data[NODE_INFO_WIDTH-1:0];
                        h_node_info_bram_ena   <= 1'b1;
                        h_node_info_bram_wea   <= 1'b1;
                        h_node_info_bram_addra <= seg_cnt[NODE_INFO_ADDR_W-1:0];
                        if (seg_last) begin
                            state_q      <= LOAD_W;
                            ni_wr_last_q <= 1'b1;
                        end
                    end
                    LOAD_W: begin
                        wgt_bram_din   <= s_data[DATA_WIDTH-1:0];
                        wgt_bram_ena   <= 1'b1;
                        wgt_bram_wea   <= 1'b1;
                        wgt_bram_addra <= seg_cnt[WEIGHT_ADDR_W-1:0];
                        if (seg_last) begin
                            state_q     <= DONE;
                            s_ready     <= 1'b0;
                            w_wr_last_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

endmodule
